// File: rtl/load_store_unit.sv
// Load/store unit: drives a req/gnt/rvalid data-memory port, aligns store lanes, extends loads, aborts on timeout.
// Optional macro LSU_MISALIGN_TRAP_EN adds misalign_err and traps misaligned half/word accesses.
module load_store_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [ADDR_WIDTH-1:0] in_alu_out_m,
    input  logic [DATA_WIDTH-1:0] write_data_mem,
    input  logic                  mem_write_m,
    input  logic [1:0]            mem_size_m,
    input  logic                  mem_unsigned_m,
    output logic                  stall_out,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_valid,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    output logic [3:0]            bus_be,
    input  logic                  bus_gnt,
    input  logic                  bus_rvalid,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    output logic                  bus_err
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    output logic                  misalign_err
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0] state;
    logic [7:0] tmo_cnt;
    logic [1:0] size_q;
    logic [1:0] off_q;
    logic       uns_q;
    logic       timed_out;

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   lane_be = 4'b0001 << off;
            2'b01:   lane_be = off[1] ? 4'b1100 : 4'b0011;
            default: lane_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] align_wdata(input logic [1:0] size,
                                                          input logic [DATA_WIDTH-1:0] data);
        case (size)
            2'b00:   align_wdata = {4{data[7:0]}};
            2'b01:   align_wdata = {2{data[15:0]}};
            default: align_wdata = data;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] extract_load(input logic [1:0] size,
                                                           input logic [1:0] off,
                                                           input logic uns,
                                                           input logic [DATA_WIDTH-1:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[{off, 3'b000} +: 8];
        h = rdata[{off[1], 4'b0000} +: 16];
        case (size)
            2'b00:   extract_load = {{24{~uns & b[7]}}, b};
            2'b01:   extract_load = {{16{~uns & h[15]}}, h};
            default: extract_load = rdata;
        endcase
    endfunction

`ifdef LSU_MISALIGN_TRAP_EN
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   is_misaligned = 1'b0;
            2'b01:   is_misaligned = off[0];
            default: is_misaligned = |off;
        endcase
    endfunction
`endif

    always_comb begin
        stall_out = (state == IDLE && in_valid) || state == REQ || state == WAIT;
        timed_out = (tmo_cnt >= TMO_LAST);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            tmo_cnt    <= '0;
            size_q     <= '0;
            off_q      <= '0;
            uns_q      <= 1'b0;
            load_data  <= '0;
            load_valid <= 1'b0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            bus_be     <= '0;
            bus_err    <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_err <= 1'b0;
`endif
        end else begin
            // Status outputs are single-cycle pulses unless re-armed below.
            load_valid <= 1'b0;
            bus_err    <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    if (in_valid) begin
                        bus_addr  <= {in_alu_out_m[ADDR_WIDTH-1:2], 2'b00};
                        bus_we    <= mem_write_m;
                        bus_be    <= lane_be(mem_size_m, in_alu_out_m[1:0]);
                        bus_wdata <= align_wdata(mem_size_m, write_data_mem);
                        size_q    <= mem_size_m;
                        off_q     <= in_alu_out_m[1:0];
                        uns_q     <= mem_unsigned_m;
`ifdef LSU_MISALIGN_TRAP_EN
                        if (is_misaligned(mem_size_m, in_alu_out_m[1:0])) begin
                            misalign_err <= 1'b1;
                            load_data    <= '0;
                            load_valid   <= ~mem_write_m;
                            state        <= DONE;
                        end else begin
                            bus_req <= 1'b1;
                            state   <= REQ;
                        end
`else
                        bus_req <= 1'b1;
                        state   <= REQ;
`endif
                    end
                end
                REQ: begin
                    // The counter keeps running into WAIT so the budget covers REQ+WAIT together.
                    if (bus_gnt) begin
                        bus_req <= 1'b0;
                        tmo_cnt <= tmo_cnt + 8'd1;
                        state   <= bus_we ? DONE : WAIT;
                    end else if (timed_out) begin
                        bus_req    <= 1'b0;
                        bus_err    <= 1'b1;
                        load_data  <= '0;
                        load_valid <= ~bus_we;
                        state      <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                WAIT: begin
                    if (bus_rvalid) begin
                        load_data  <= extract_load(size_q, off_q, uns_q, bus_rdata);
                        load_valid <= 1'b1;
                        state      <= DONE;
                    end else if (timed_out) begin
                        bus_err    <= 1'b1;
                        load_data  <= '0;
                        load_valid <= 1'b1;
                        state      <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                default: begin
                    tmo_cnt <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stores, signed/unsigned loads, delayed handshake, timeout, reset, misalignment.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_alu_out_m;
    logic [31:0] write_data_mem;
    logic        mem_write_m;
    logic [1:0]  mem_size_m;
    logic        mem_unsigned_m;
    logic        stall_out;
    logic [31:0] load_data;
    logic        load_valid;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        bus_err;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        misalign_err;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_alu_out_m   (in_alu_out_m),
        .write_data_mem (write_data_mem),
        .mem_write_m    (mem_write_m),
        .mem_size_m     (mem_size_m),
        .mem_unsigned_m (mem_unsigned_m),
        .stall_out      (stall_out),
        .load_data      (load_data),
        .load_valid     (load_valid),
        .bus_req        (bus_req),
        .bus_we         (bus_we),
        .bus_addr       (bus_addr),
        .bus_wdata      (bus_wdata),
        .bus_be         (bus_be),
        .bus_gnt        (bus_gnt),
        .bus_rvalid     (bus_rvalid),
        .bus_rdata      (bus_rdata),
        .bus_err        (bus_err)
`ifdef LSU_MISALIGN_TRAP_EN
        ,
        .misalign_err   (misalign_err)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic v, input logic [31:0] a, input logic [31:0] d,
                          input logic we, input logic [1:0] sz, input logic u);
        in_valid       = v;
        in_alu_out_m   = a;
        write_data_mem = d;
        mem_write_m    = we;
        mem_size_m     = sz;
        mem_unsigned_m = u;
    endtask

    task automatic test_reset;
        reset = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
        set_op(1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0);
        tick; tick;
        total++; if ({bus_req, bus_we, load_valid, bus_err} !== 4'b0000) begin bad++; $display("FAIL rst_ctrl got=%b expected=0000", {bus_req, bus_we, load_valid, bus_err}); end
        total++; if (bus_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h expected=0", bus_addr); end
        total++; if (bus_wdata !== 32'h0) begin bad++; $display("FAIL rst_wdata got=%h expected=0", bus_wdata); end
        total++; if (bus_be !== 4'h0) begin bad++; $display("FAIL rst_be got=%b expected=0000", bus_be); end
        total++; if (load_data !== 32'h0) begin bad++; $display("FAIL rst_load_data got=%h expected=0", load_data); end
        total++; if (stall_out !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b expected=0", stall_out); end
        reset = 1'b1;
        tick;
    endtask

    task automatic test_store_word;
        int stall_cnt;
        stall_cnt = 0;
        set_op(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 2'b10, 1'b0);
        bus_gnt = 1'b1;
        #1;
        if (stall_out === 1'b1) stall_cnt++;
        tick;
        if (stall_out === 1'b1) stall_cnt++;
        total++; if (bus_req !== 1'b1) begin bad++; $display("FAIL sw_req got=%b expected=1", bus_req); end
        total++; if (bus_addr !== 32'h0000_0010) begin bad++; $display("FAIL sw_addr got=%h expected=00000010", bus_addr); end
        total++; if (bus_be !== 4'b1111) begin bad++; $display("FAIL sw_be got=%b expected=1111", bus_be); end
        total++; if (bus_wdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL sw_wdata got=%h expected=deadbeef", bus_wdata); end
        total++; if (bus_we !== 1'b1) begin bad++; $display("FAIL sw_we got=%b expected=1", bus_we); end
        tick;
        in_valid = 1'b0; bus_gnt = 1'b0;
        #1;
        if (stall_out === 1'b1) stall_cnt++;
        total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL sw_req_drop got=%b expected=0", bus_req); end
        total++; if (load_valid !== 1'b0) begin bad++; $display("FAIL sw_no_lv_done got=%b expected=0", load_valid); end
        tick;
        total++; if (load_valid !== 1'b0) begin bad++; $display("FAIL sw_no_lv_idle got=%b expected=0", load_valid); end
        total++; if (stall_cnt != 2) begin bad++; $display("FAIL sw_stall_cycles got=%0d expected=2", stall_cnt); end
    endtask

    task automatic test_store_byte;
        set_op(1'b1, 32'h0000_0013, 32'h0000_00A5, 1'b1, 2'b00, 1'b0);
        bus_gnt = 1'b1;
        tick;
        total++; if (bus_be !== 4'b1000) begin bad++; $display("FAIL sb_be got=%b expected=1000", bus_be); end
        total++; if (bus_wdata !== 32'hA5A5_A5A5) begin bad++; $display("FAIL sb_wdata got=%h expected=a5a5a5a5", bus_wdata); end
        total++; if (bus_addr !== 32'h0000_0010) begin bad++; $display("FAIL sb_addr got=%h expected=00000010", bus_addr); end
        tick;
        in_valid = 1'b0; bus_gnt = 1'b0;
        tick;
    endtask

    task automatic test_load_byte(input logic uns, input logic [31:0] exp);
        set_op(1'b1, 32'h0000_0021, 32'h0, 1'b0, 2'b00, uns);
        bus_gnt = 1'b1;
        tick;
        total++; if (bus_be !== 4'b0010) begin bad++; $display("FAIL lb_be uns=%0b got=%b expected=0010", uns, bus_be); end
        total++; if (bus_we !== 1'b0) begin bad++; $display("FAIL lb_we uns=%0b got=%b expected=0", uns, bus_we); end
        // rvalid arriving with gnt must not be taken as the load result
        bus_rvalid = 1'b1; bus_rdata = 32'hAAAA_AAAA;
        tick;
        bus_gnt = 1'b0; bus_rdata = 32'h1234_80FF;
        total++; if (load_valid !== 1'b0) begin bad++; $display("FAIL lb_early_lv uns=%0b got=%b expected=0", uns, load_valid); end
        total++; if (stall_out !== 1'b1) begin bad++; $display("FAIL lb_wait_stall uns=%0b got=%b expected=1", uns, stall_out); end
        tick;
        bus_rvalid = 1'b0; in_valid = 1'b0;
        total++; if (load_valid !== 1'b1) begin bad++; $display("FAIL lb_lv uns=%0b got=%b expected=1", uns, load_valid); end
        total++; if (load_data !== exp) begin bad++; $display("FAIL lb_data uns=%0b got=%h expected=%h", uns, load_data, exp); end
        tick;
        total++; if (load_valid !== 1'b0) begin bad++; $display("FAIL lb_lv_pulse uns=%0b got=%b expected=0", uns, load_valid); end
    endtask

    task automatic test_load_half_delays;
        set_op(1'b1, 32'h0000_0042, 32'h0, 1'b0, 2'b01, 1'b0);
        bus_gnt = 1'b0;
        tick;
        for (int i = 0; i < 3; i++) begin
            total++; if (bus_req !== 1'b1) begin bad++; $display("FAIL lh_req cyc=%0d got=%b expected=1", i, bus_req); end
            total++; if (bus_addr !== 32'h0000_0040) begin bad++; $display("FAIL lh_addr cyc=%0d got=%h expected=00000040", i, bus_addr); end
            total++; if (bus_be !== 4'b1100) begin bad++; $display("FAIL lh_be cyc=%0d got=%b expected=1100", i, bus_be); end
            total++; if (stall_out !== 1'b1) begin bad++; $display("FAIL lh_stall_req cyc=%0d got=%b expected=1", i, stall_out); end
            if (i == 2) bus_gnt = 1'b1;
            tick;
        end
        bus_gnt = 1'b0;
        total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL lh_req_drop got=%b expected=0", bus_req); end
        total++; if (stall_out !== 1'b1) begin bad++; $display("FAIL lh_stall_wait1 got=%b expected=1", stall_out); end
        tick;
        bus_rvalid = 1'b1; bus_rdata = 32'h8001_7FFF;
        total++; if (stall_out !== 1'b1) begin bad++; $display("FAIL lh_stall_wait2 got=%b expected=1", stall_out); end
        total++; if (load_valid !== 1'b0) begin bad++; $display("FAIL lh_early_lv got=%b expected=0", load_valid); end
        tick;
        bus_rvalid = 1'b0; in_valid = 1'b0;
        total++; if (load_valid !== 1'b1) begin bad++; $display("FAIL lh_lv got=%b expected=1", load_valid); end
        total++; if (load_data !== 32'hFFFF_8001) begin bad++; $display("FAIL lh_data got=%h expected=ffff8001", load_data); end
        total++; if (stall_out !== 1'b0) begin bad++; $display("FAIL lh_stall_done got=%b expected=0", stall_out); end
        tick;
    endtask

    task automatic test_reset_mid_op;
        set_op(1'b1, 32'h0000_0200, 32'h0000_0055, 1'b0, 2'b10, 1'b0);
        bus_gnt = 1'b1;
        tick;
        tick;
        bus_gnt = 1'b0;
        total++; if (stall_out !== 1'b1) begin bad++; $display("FAIL rm_in_wait got=%b expected=1", stall_out); end
        reset = 1'b0; in_valid = 1'b0;
        tick;
        reset = 1'b1;
        total++; if (bus_addr !== 32'h0) begin bad++; $display("FAIL rm_addr got=%h expected=0", bus_addr); end
        total++; if (bus_be !== 4'h0) begin bad++; $display("FAIL rm_be got=%b expected=0000", bus_be); end
        total++; if (load_data !== 32'h0) begin bad++; $display("FAIL rm_load_data got=%h expected=0", load_data); end
        total++; if ({bus_req, load_valid, bus_err} !== 3'b000) begin bad++; $display("FAIL rm_ctrl got=%b expected=000", {bus_req, load_valid, bus_err}); end
        total++; if (stall_out !== 1'b0) begin bad++; $display("FAIL rm_stall got=%b expected=0", stall_out); end
        bus_rvalid = 1'b1; bus_rdata = 32'h1234_5678;
        tick;
        bus_rvalid = 1'b0;
        tick;
        total++; if (load_valid !== 1'b0) begin bad++; $display("FAIL rm_late_lv got=%b expected=0", load_valid); end
        total++; if (load_data !== 32'h0) begin bad++; $display("FAIL rm_late_data got=%h expected=0", load_data); end
    endtask

    task automatic test_back_to_back;
        set_op(1'b1, 32'h0000_0030, 32'h1122_3344, 1'b1, 2'b10, 1'b0);
        bus_gnt = 1'b1;
        tick;
        tick;
        set_op(1'b1, 32'h0000_0034, 32'h0, 1'b0, 2'b01, 1'b1);
        #1;
        total++; if (stall_out !== 1'b0) begin bad++; $display("FAIL bb_done_stall got=%b expected=0", stall_out); end
        tick;
        total++; if (stall_out !== 1'b1) begin bad++; $display("FAIL bb_idle_stall got=%b expected=1", stall_out); end
        total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL bb_no_accept_in_done got=%b expected=0", bus_req); end
        tick;
        total++; if (bus_req !== 1'b1) begin bad++; $display("FAIL bb_req got=%b expected=1", bus_req); end
        total++; if (bus_addr !== 32'h0000_0034) begin bad++; $display("FAIL bb_addr got=%h expected=00000034", bus_addr); end
        total++; if (bus_be !== 4'b0011) begin bad++; $display("FAIL bb_be got=%b expected=0011", bus_be); end
        tick;
        bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hCAFE_9876;
        tick;
        bus_rvalid = 1'b0; in_valid = 1'b0;
        total++; if (load_data !== 32'h0000_9876) begin bad++; $display("FAIL bb_data got=%h expected=00009876", load_data); end
        total++; if (load_valid !== 1'b1) begin bad++; $display("FAIL bb_lv got=%b expected=1", load_valid); end
        tick;
    endtask

    task automatic test_misalign;
`ifdef LSU_MISALIGN_TRAP_EN
        set_op(1'b1, 32'h0000_0006, 32'h0, 1'b0, 2'b10, 1'b0);
        bus_gnt = 1'b1;
        #1;
        total++; if (stall_out !== 1'b1) begin bad++; $display("FAIL ma_stall got=%b expected=1", stall_out); end
        tick;
        in_valid = 1'b0; bus_gnt = 1'b0;
        total++; if (misalign_err !== 1'b1) begin bad++; $display("FAIL ma_err got=%b expected=1", misalign_err); end
        total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL ma_no_req got=%b expected=0", bus_req); end
        total++; if (load_valid !== 1'b1) begin bad++; $display("FAIL ma_lv got=%b expected=1", load_valid); end
        total++; if (load_data !== 32'h0) begin bad++; $display("FAIL ma_data got=%h expected=0", load_data); end
        tick;
        total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL ma_err_pulse got=%b expected=0", misalign_err); end
        total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL ma_idle_req got=%b expected=0", bus_req); end
`else
        set_op(1'b1, 32'h0000_0006, 32'h0, 1'b0, 2'b10, 1'b0);
        bus_gnt = 1'b1;
        tick;
        total++; if (bus_addr !== 32'h0000_0004) begin bad++; $display("FAIL ma_addr got=%h expected=00000004", bus_addr); end
        total++; if (bus_be !== 4'b1111) begin bad++; $display("FAIL ma_be got=%b expected=1111", bus_be); end
        tick;
        bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h0BAD_F00D;
        tick;
        bus_rvalid = 1'b0; in_valid = 1'b0;
        total++; if (load_data !== 32'h0BAD_F00D) begin bad++; $display("FAIL ma_data got=%h expected=0badf00d", load_data); end
        tick;
`endif
    endtask

    task automatic test_timeout;
        set_op(1'b1, 32'h0000_0100, 32'h0, 1'b0, 2'b10, 1'b0);
        bus_gnt = 1'b0; bus_rvalid = 1'b0;
        tick;
        for (int i = 0; i < 8; i++) begin
            total++; if (bus_req !== 1'b1) begin bad++; $display("FAIL to_req cyc=%0d got=%b expected=1", i, bus_req); end
            total++; if (bus_err !== 1'b0) begin bad++; $display("FAIL to_early_err cyc=%0d got=%b expected=0", i, bus_err); end
            tick;
        end
        in_valid = 1'b0;
        total++; if (bus_err !== 1'b1) begin bad++; $display("FAIL to_err got=%b expected=1", bus_err); end
        total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL to_req_drop got=%b expected=0", bus_req); end
        total++; if (load_valid !== 1'b1) begin bad++; $display("FAIL to_lv got=%b expected=1", load_valid); end
        total++; if (load_data !== 32'h0) begin bad++; $display("FAIL to_data got=%h expected=0", load_data); end
        tick;
        total++; if ({bus_err, load_valid, stall_out} !== 3'b000) begin bad++; $display("FAIL to_idle got=%b expected=000", {bus_err, load_valid, stall_out}); end
    endtask

    initial begin
        test_reset;
        test_store_word;
        test_store_byte;
        test_load_byte(1'b0, 32'hFFFF_FF80);
        test_load_byte(1'b1, 32'h0000_0080);
        test_load_half_delays;
        test_reset_mid_op;
        test_back_to_back;
        test_misalign;
        test_timeout;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface: takes one load/store per request from the pipeline's memory stage and drives a data memory over a req/gnt/rvalid handshake.
- Generates byte enables, aligns store data to byte lanes, and extracts plus sign/zero-extends load data.
- Stalls the pipeline while a transaction is outstanding.
- Sits between the execute/memory pipeline register and the data memory (or a bus adapter in front of it).

Parameters:
- DATA_WIDTH, 32, data path width; fixed at 32 for byte-lane logic.
- ADDR_WIDTH, 32, byte address width.
- TIMEOUT_CYCLES, 255, max cycles spent in REQ+WAIT before abort; 8-bit counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  memory op present this cycle; held stable while stall_out=1.
- in_alu_out_m  in  ADDR_WIDTH  byte address.
- write_data_mem  in  DATA_WIDTH  store data, right-justified.
- mem_write_m  in  1  1=store, 0=load.
- mem_size_m  in  2  00 byte, 01 half, 10/11 word.
- mem_unsigned_m  in  1  1=zero-extend load, 0=sign-extend.
- stall_out  out  1  freeze upstream pipeline.
- load_data  out  DATA_WIDTH  extended load result.
- load_valid  out  1  one-cycle pulse: load_data valid.
- bus_req  out  1  request to memory.
- bus_we  out  1  write strobe.
- bus_addr  out  ADDR_WIDTH  word-aligned address (addr[1:0]=00).
- bus_wdata  out  DATA_WIDTH  lane-aligned store data.
- bus_be  out  4  byte enables, little-endian.
- bus_gnt  in  1  memory accepted request this cycle.
- bus_rvalid  in  1  read data valid.
- bus_rdata  in  DATA_WIDTH  read data.
- bus_err  out  1  one-cycle pulse: timeout abort.

Behaviour:
- Reset (reset=0 at clk edge) from any state:
  - state goes to IDLE and the counter clears.
  - All registered outputs go to 0: load_data, load_valid, bus_req, bus_we, bus_addr, bus_wdata, bus_be, bus_err.
  - Any in-flight transaction is dropped; a late bus_rvalid after reset is ignored.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - On in_valid=1, latch address, size, unsigned flag, write flag and lane-aligned data.
  - Next state REQ; bus_req rises the next cycle.
- REQ:
  - bus_req=1; bus_addr, bus_we, bus_be, bus_wdata held stable until bus_gnt.
  - gnt with store: go to DONE.
  - gnt with load: go to WAIT.
  - bus_req drops the cycle after gnt.
- WAIT:
  - On bus_rvalid, capture extracted/extended data into load_data and go to DONE.
  - rvalid in the same cycle as gnt (REQ state) is ignored; memory must return data at least 1 cycle after gnt.
- DONE:
  - load_valid=1 for loads only, one cycle; then IDLE.
  - A new in_valid is not accepted in DONE.
- stall_out:
  - Combinational: 1 when (IDLE and in_valid) or state is REQ or WAIT; 0 in DONE.
  - Minimum latency: load 4 cycles (IDLE→REQ→WAIT→DONE with gnt and rvalid immediate); store 3 cycles.
- Timeout:
  - Counter increments each cycle in REQ or WAIT and clears on entering IDLE.
  - At TIMEOUT_CYCLES: bus_err pulses 1 cycle, bus_req drops, load_data=0, go to DONE. load_valid still pulses for loads so the pipeline completes.
- Lane rules, with off = addr[1:0]:
  - Byte: be = 0001 << off; wdata = byte replicated in all 4 lanes.
  - Half: be = 0011 if addr[1]=0, else 1100; wdata = half replicated.
  - Word: be = 1111.
  - Loads drive bus_be with the same pattern; the memory may ignore it.
  - Load extract: byte = rdata[8*off+7 : 8*off]; half = rdata[16*addr[1]+15 : 16*addr[1]]. Extend per mem_unsigned_m.
- Misalignment without the macro: half ignores addr[0]; word ignores addr[1:0].

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - Extra output misalign_err (1 bit, reset 0).
  - Misaligned means half with addr[0]=1, or word with addr[1:0]≠00.
  - On a misaligned request: IDLE→DONE directly, no bus_req, misalign_err pulses 1 cycle, load_data=0, load_valid pulses for loads.
- Undefined: port absent; misaligned accesses silently aligned as above.

Test Plan:
- Store word: addr 0x0000_0010, data 0xDEADBEEF, gnt immediate → bus_addr=0x10, be=1111, wdata=0xDEADBEEF, we=1; stall high 2 cycles; no load_valid.
- Store byte: addr 0x0000_0013, data 0x0000_00A5 → be=1000, wdata=0xA5A5A5A5.
- Load byte signed: addr 0x0000_0021, rdata 0x1234_80FF → load_data=0xFFFF_FF80. Same with unsigned=1 → 0x0000_0080.
- Load half with delays: addr 0x0000_0042, gnt after 3 cycles, rvalid 2 cycles later, rdata 0x8001_7FFF → load_data=0xFFFF_8001; stall held throughout; bus signals stable in REQ.
- Timeout: TIMEOUT_CYCLES=8, gnt never asserted → bus_err pulse after 8 REQ cycles, load_data=0, load_valid pulse, return to IDLE.
- Reset mid-op: reset=0 in WAIT → next cycle IDLE, all outputs 0; later rvalid ignored. With LSU_MISALIGN_TRAP_EN: word load at 0x0000_0006 → misalign_err pulse, no bus_req.
